// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and a counter-width helper.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bits needed to count 0..v-1 (never less than 1).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Handshake/operand bundle for seq_shift_add_mult.
// The is_signed signal exists only when MULT_SIGNED_EN is defined.
interface seq_shift_add_mult_if #(parameter int WIDTH = 4) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef MULT_SIGNED_EN
  logic                 is_signed;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

`ifdef MULT_SIGNED_EN
  modport master (output start, a, b, is_signed, input busy, done, product);
  modport slave  (input start, a, b, is_signed, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif

endinterface

// File: rtl/add_nbit.sv
// N-bit ripple-carry adder with carry-out; the single shared adder of the multiplier.
module add_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// WIDTH x WIDTH sequential shift-and-add multiplier, one partial product per cycle.
// Optional signed mode via macro MULT_SIGNED_EN (magnitude multiply plus final negate).
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_shift_add_mult_if.slave   bus
);

  localparam int CNT_W = clog2(WIDTH);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     a_in, b_in, addend, sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   result;

`ifdef MULT_SIGNED_EN
  logic                 neg_q, neg_d;

  // Magnitude of a two's complement operand; -2^(W-1) maps to 2^(W-1) as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (2*WIDTH)'(-v) : v;
  endfunction

  assign a_in   = magnitude(bus.a, bus.is_signed);
  assign b_in   = magnitude(bus.b, bus.is_signed);
  assign neg_d  = (state_q == IDLE && bus.start) ? (bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]))
                                                 : neg_q;
  assign result = sign_fix(acc_step, neg_q);
`else
  assign a_in   = bus.a;
  assign b_in   = bus.b;
  assign result = acc_step;
`endif

  assign addend   = mplr_q[0] ? mcand_q : '0;
  // Shift {carry, sum, acc_lo} right by one: the dropped LSB is the finished product bit.
  assign acc_step = {carry, sum, acc_q[WIDTH-1:1]};

  add_nbit #(.N(WIDTH)) u_add (
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = a_in;
          mplr_d  = b_in;
          acc_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_step;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + 1'b1;
        // Product is loaded on entry to DONE so it is valid while done is high.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = result;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
    acc_q   <= acc_d;
`ifdef MULT_SIGNED_EN
    neg_q   <= neg_d;
`endif
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH=4 and WIDTH=8 (signed cases with MULT_SIGNED_EN).
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_shift_add_mult_if #(.WIDTH(4)) if4 ();
  seq_shift_add_mult_if #(.WIDTH(8)) if8 ();

  seq_shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int total = 0;
  int bad   = 0;

  int          sel = 4;
  logic        cur_busy, cur_done;
  logic [15:0] cur_prod;

  always_comb begin
    if (sel == 8) begin
      cur_busy = if8.busy;
      cur_done = if8.done;
      cur_prod = if8.product;
    end else begin
      cur_busy = if4.busy;
      cur_done = if4.done;
      cur_prod = {8'h00, if4.product};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (s == 8) begin
      if8.start = st; if8.a = a; if8.b = b;
    end else begin
      if4.start = st; if4.a = a[3:0]; if4.b = b[3:0];
    end
  endtask

  // Waits (bounded) for done on the selected DUT; returns edges waited and busy cycles seen.
  task automatic wait_done(input string tag, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!cur_done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (cur_busy) bc++;
    end
    if (!cur_done) chk({tag, "_timeout"}, 32'(cur_done), 32'd1);
  endtask

  task automatic run(input int s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int n, bc;
    sel = s;
    @(negedge clk); drive(s, 1'b1, a, b);
    @(posedge clk); #1;
    chk({tag, "_busy"}, 32'(cur_busy), 32'd1);
    @(negedge clk); drive(s, 1'b0, 8'h00, 8'h00);
    wait_done(tag, n, bc);
    chk({tag, "_lat"}, 32'(n), 32'(s));
    chk({tag, "_busycnt"}, 32'(bc + 1), 32'(s));
    chk({tag, "_prod"}, 32'(cur_prod), 32'(exp));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(cur_done), 32'd0);
    chk({tag, "_hold"}, 32'(cur_prod), 32'(exp));
  endtask

  initial begin
    int  n, bc;
    logic seen;
    rst = 1'b1;
    drive(4, 1'b1, 8'h03, 8'h05);
    drive(8, 1'b1, 8'h03, 8'h05);
`ifdef MULT_SIGNED_EN
    if4.is_signed = 1'b0;
    if8.is_signed = 1'b0;
`endif
    // Reset with start held high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_done", 32'(if4.done), 32'd0);
    chk("rst_prod", 32'(if4.product), 32'd0);
    chk("rst_prod8", 32'(if8.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(4, 1'b0, 8'h00, 8'h00);
    drive(8, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("rst_noaccept", 32'(if4.busy), 32'd0);

    run(4, 8'd3,  8'd5,  16'd15,  "basic_3x5");
    run(4, 8'd15, 8'd15, 16'hE1,  "max_15x15");
    run(4, 8'd0,  8'd9,  16'd0,   "zero_0x9");
    run(4, 8'd1,  8'd15, 16'd15,  "one_1x15");
    run(8, 8'd255, 8'd255, 16'd65025, "w8_255x255");

    // Start held continuously; restart only in the IDLE cycle after done
    sel = 4;
    @(negedge clk); drive(4, 1'b1, 8'd2, 8'd7);
    @(posedge clk); #1;
    chk("held_busy", 32'(cur_busy), 32'd1);
    wait_done("held", n, bc);
    chk("held_lat", 32'(n), 32'd4);
    chk("held_prod", 32'(cur_prod), 32'd14);
    @(posedge clk); #1;
    chk("held_idle", 32'(cur_busy), 32'd0);
    @(posedge clk); #1;
    chk("held_reaccept", 32'(cur_busy), 32'd1);
    @(negedge clk); drive(4, 1'b0, 8'd15, 8'd15);
    wait_done("midchg", n, bc);
    chk("midchg_prod", 32'(cur_prod), 32'd14);

    // Reset during the second RUN cycle
    @(posedge clk);
    @(negedge clk); drive(4, 1'b1, 8'd9, 8'd9);
    @(posedge clk);
    @(negedge clk); drive(4, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(cur_busy), 32'd0);
    chk("abort_done", 32'(cur_done), 32'd0);
    chk("abort_prod", 32'(cur_prod), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cur_done) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run(4, 8'd3, 8'd5, 16'd15, "after_abort");

`ifdef MULT_SIGNED_EN
    if4.is_signed = 1'b1;
    run(4, 8'h8, 8'h7, 16'hC8, "s_m8x7");
    run(4, 8'h8, 8'h8, 16'h40, "s_m8xm8");
    run(4, 8'hF, 8'hF, 16'h01, "s_m1xm1");
    if4.is_signed = 1'b0;
    run(4, 8'hF, 8'hF, 16'hE1, "u_FxF");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
